uart_tx_controller: RTL and testbench



---
 rtl/uart_tx_controller.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_controller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_controller.sv
// UART transmit sequencer: start bit, 8 data bits LSB first, optional parity bit, stop bit(s).
// Define UART_TX_TWO_STOP_EN to append a second stop bit (STOP2) before TxDone.
module uart_tx_controller #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       TxStart,
    input  logic [7:0] Din,
    input  logic       ParityEn,
    input  logic       ParitySelect,
    output logic [7:0] PgDin,
    output logic       PgSelect,
    input  logic       PgParityBit,
    output logic       TxOut,
    output logic       TxBusy,
    output logic       TxDone
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_TWO_STOP_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       pg_din_reg, pg_din_next;
    logic             pg_sel_reg, pg_sel_next;
    logic             par_en_reg, par_en_next;
    logic             tx_out_reg, tx_out_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             period_end;
    logic [2:0]       idx_inc;

    assign period_end = (cnt_reg == CNT_LAST);
    assign idx_inc    = idx_reg + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            pg_din_reg <= '0;
            pg_sel_reg <= 1'b0;
            par_en_reg <= 1'b0;
            tx_out_reg <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            pg_din_reg <= pg_din_next;
            pg_sel_reg <= pg_sel_next;
            par_en_reg <= par_en_next;
            tx_out_reg <= tx_out_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    // TxOut is only ever loaded at a bit-period boundary, so the line cannot glitch.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        pg_din_next = pg_din_reg;
        pg_sel_next = pg_sel_reg;
        par_en_next = par_en_reg;
        tx_out_next = tx_out_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;

        if (state_reg != IDLE) begin
            cnt_next = period_end ? '0 : cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            IDLE: begin
                if (TxStart) begin
                    pg_din_next = Din;
                    pg_sel_next = ParitySelect;
                    par_en_next = ParityEn;
                    state_next  = START;
                    cnt_next    = '0;
                    tx_out_next = 1'b0;
                    busy_next   = 1'b1;
                end
            end
            START: begin
                if (period_end) begin
                    state_next  = DATA;
                    idx_next    = 3'd0;
                    tx_out_next = pg_din_reg[0];
                end
            end
            DATA: begin
                if (period_end) begin
                    if (idx_reg == 3'd7) begin
                        idx_next = 3'd0;
                        if (par_en_reg) begin
                            state_next  = PARITY;
                            tx_out_next = PgParityBit;
                        end else begin
                            state_next  = STOP;
                            tx_out_next = 1'b1;
                        end
                    end else begin
                        idx_next    = idx_inc;
                        tx_out_next = pg_din_reg[idx_inc];
                    end
                end
            end
            PARITY: begin
                if (period_end) begin
                    state_next  = STOP;
                    tx_out_next = 1'b1;
                end
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP: begin
                if (period_end) begin
                    state_next  = STOP2;
                    tx_out_next = 1'b1;
                end
            end
            STOP2: begin
                if (period_end) begin
                    state_next  = IDLE;
                    tx_out_next = 1'b1;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                end
            end
`else
            STOP: begin
                if (period_end) begin
                    state_next  = IDLE;
                    tx_out_next = 1'b1;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                end
            end
`endif
            default: begin
                state_next  = IDLE;
                cnt_next    = '0;
                tx_out_next = 1'b1;
                busy_next   = 1'b0;
            end
        endcase
    end

    assign PgDin    = pg_din_reg;
    assign PgSelect = pg_sel_reg;
    assign TxOut    = tx_out_reg;
    assign TxBusy   = busy_reg;
    assign TxDone   = done_reg;
endmodule

// File: tb/tb_uart_tx_controller.sv
// Self-checking bench for uart_tx_controller at CLKS_PER_BIT=4: vector table, corner sequences, random frames.
module tb_uart_tx_controller;
    localparam int CPB = 4;
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       TxStart;
    logic [7:0] Din;
    logic       ParityEn;
    logic       ParitySelect;
    logic [7:0] PgDin;
    logic       PgSelect;
    logic       PgParityBit;
    logic       TxOut;
    logic       TxBusy;
    logic       TxDone;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] din;
        logic       pen;
        logic       psel;
        logic       par;
        int         len;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    // Stand-in for the external parity generator.
    assign PgParityBit = (^PgDin) ^ PgSelect;

    uart_tx_controller #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst(rst),
        .TxStart(TxStart),
        .Din(Din),
        .ParityEn(ParityEn),
        .ParitySelect(ParitySelect),
        .PgDin(PgDin),
        .PgSelect(PgSelect),
        .PgParityBit(PgParityBit),
        .TxOut(TxOut),
        .TxBusy(TxBusy),
        .TxDone(TxDone)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected line levels, one entry per bit period; positions past the frame read as idle-high.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic pen, input logic par);
        logic [15:0] b;
        int          n;
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1 + i] = d[i];
        n = 9;
        if (pen) begin
            b[n] = par;
            n++;
        end
        return b;
    endfunction

    // Accept one frame and check every cycle until one past TxDone.
    task automatic run_frame(input logic [7:0] d, input logic pen, input logic psel,
                             input logic par, input int base_len, input bit hold, input string tag);
        logic [15:0] bits;
        int          len;
        bits = frame_bits(d, pen, par);
        len  = base_len + (STOP_BITS - 1) * CPB;
        Din = d; ParityEn = pen; ParitySelect = psel; TxStart = 1'b1;
        @(posedge clk); #1;
        if (hold) Din = 8'hFF;
        else TxStart = 1'b0;
        for (int k = 0; k < len; k++) begin
            check($sformatf("%s cyc%0d {out,busy,done}", tag, k + 1),
                  {29'd0, TxOut, TxBusy, TxDone}, {29'd0, bits[k / CPB], 1'b1, 1'b0});
            @(posedge clk); #1;
        end
        check($sformatf("%s done {out,busy,done}", tag), {29'd0, TxOut, TxBusy, TxDone}, 32'b101);
        check($sformatf("%s PgDin", tag), {24'd0, PgDin}, {24'd0, d});
        check($sformatf("%s PgSelect", tag), {31'd0, PgSelect}, {31'd0, psel});
        $display("frame %s din=0x%02h pen=%0d psel=%0d len=%0d", tag, d, pen, psel, len);
        if (!hold) begin
            @(posedge clk); #1;
            check($sformatf("%s idle {out,busy,done}", tag), {29'd0, TxOut, TxBusy, TxDone}, 32'b100);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       rpen, rsel;

        tbl[0] = '{din: 8'h55, pen: 1'b1, psel: 1'b0, par: 1'b0, len: 44};
        tbl[1] = '{din: 8'h07, pen: 1'b1, psel: 1'b0, par: 1'b1, len: 44};
        tbl[2] = '{din: 8'h07, pen: 1'b1, psel: 1'b1, par: 1'b0, len: 44};
        tbl[3] = '{din: 8'h07, pen: 1'b0, psel: 1'b0, par: 1'b0, len: 40};
        tbl[4] = '{din: 8'h00, pen: 1'b0, psel: 1'b0, par: 1'b0, len: 40};
        tbl[5] = '{din: 8'hFF, pen: 1'b1, psel: 1'b1, par: 1'b1, len: 44};
        tbl[6] = '{din: 8'h80, pen: 1'b1, psel: 1'b0, par: 1'b1, len: 44};

        // Reset held with TxStart asserted must not start a frame.
        rst = 1'b1; TxStart = 1'b1; Din = 8'hAA; ParityEn = 1'b1; ParitySelect = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("reset cyc%0d {out,busy,done}", c), {29'd0, TxOut, TxBusy, TxDone}, 32'b100);
            check($sformatf("reset cyc%0d PgDin", c), {24'd0, PgDin}, 32'h00);
        end
        rst = 1'b0; TxStart = 1'b0;
        @(posedge clk); #1;
        check("post-reset idle", {29'd0, TxOut, TxBusy, TxDone}, 32'b100);

        for (int i = 0; i < 7; i++)
            run_frame(tbl[i].din, tbl[i].pen, tbl[i].psel, tbl[i].par, tbl[i].len, 1'b0,
                      $sformatf("tbl%0d", i));

        // TxStart held through a frame: ignored while busy, then accepted right after TxDone.
        run_frame(8'hA3, 1'b0, 1'b0, 1'b0, 40, 1'b1, "hold_a3");
        run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 40, 1'b0, "b2b_ff");

        // Reset in cycle 17 of a 0xF0 frame aborts it without TxDone.
        Din = 8'hF0; ParityEn = 1'b0; ParitySelect = 1'b0; TxStart = 1'b1;
        @(posedge clk); #1;
        TxStart = 1'b0;
        for (int c = 1; c < 17; c++) begin
            @(posedge clk); #1;
        end
        check("abort cyc17 TxOut", {31'd0, TxOut}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort {out,busy,done}", {29'd0, TxOut, TxBusy, TxDone}, 32'b100);
        check("abort PgDin", {24'd0, PgDin}, 32'h00);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (TxDone !== 1'b0 || TxBusy !== 1'b0 || TxOut !== 1'b1)
                check($sformatf("abort quiet cyc%0d", c), {29'd0, TxOut, TxBusy, TxDone}, 32'b100);
        end
        check("abort quiet end", {29'd0, TxOut, TxBusy, TxDone}, 32'b100);
        run_frame(8'hF0, 1'b0, 1'b0, 1'b0, 40, 1'b0, "after_abort");

        // Random frames checked against the spec-level frame model.
        for (int r = 0; r < 16; r++) begin
            rd   = 8'($urandom_range(0, 255));
            rpen = 1'($urandom_range(0, 1));
            rsel = 1'($urandom_range(0, 1));
            run_frame(rd, rpen, rsel, (^rd) ^ rsel, (10 + int'(rpen)) * CPB, 1'b0,
                      $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
